// File: rtl/seq_cpu_if.sv
// Host-side bus of seq_cpu: program loading, run control and the result/status port.
interface seq_cpu_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  wr;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [15:0]           wr_instr;
  logic                  start;
  logic [DATA_WIDTH-1:0] y;
  logic                  y_valid;
  logic                  busy;
  logic                  halted;
  logic                  err;

  modport master (
    output wr, wr_addr, wr_instr, start,
    input  y, y_valid, busy, halted, err
  );

  modport slave (
    input  wr, wr_addr, wr_instr, start,
    output y, y_valid, busy, halted, err
  );
endinterface

// File: rtl/seq_cpu.sv
// Multi-cycle FETCH/EXEC processor: 16-bit instructions from a host-loaded memory,
// four-register file, ALU with Z/C flags, jumps, conditional branch and halt.
module seq_cpu #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic      clk,
  input  logic      reset,
  seq_cpu_if.slave  bus
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_EXEC  = 2'd2;
  localparam logic [1:0] ST_HALT  = 2'd3;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDI  = 4'h1;
  localparam logic [3:0] OP_ADD  = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_AND  = 4'h4;
  localparam logic [3:0] OP_OR   = 4'h5;
  localparam logic [3:0] OP_XOR  = 4'h6;
  localparam logic [3:0] OP_SHL  = 4'h7;
  localparam logic [3:0] OP_SHR  = 4'h8;
  localparam logic [3:0] OP_MOV  = 4'h9;
  localparam logic [3:0] OP_OUT  = 4'hA;
  localparam logic [3:0] OP_JMP  = 4'hB;
  localparam logic [3:0] OP_JZ   = 4'hC;
  localparam logic [3:0] OP_HALT = 4'hD;

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [15:0]           ir_q;
  logic                  z_q, z_d;
  logic                  c_q, c_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] y_q, y_d;
  logic                  y_valid_q, y_valid_d;
  logic [DATA_WIDTH-1:0] rf_q [4];
  logic [15:0]           mem_q [DEPTH];

  logic [3:0]            op;
  logic [1:0]            rd_idx, rs_idx;
  logic [DATA_WIDTH-1:0] imm_ext, rd_val, rs_val;
  logic [DATA_WIDTH:0]   add_sum, sub_diff;
  logic                  rf_we;
  logic [DATA_WIDTH-1:0] rf_wdata;
  logic                  mem_we;

  assign op       = ir_q[15:12];
  assign rd_idx   = ir_q[11:10];
  assign rs_idx   = ir_q[9:8];
  assign imm_ext  = DATA_WIDTH'(ir_q[7:0]);
  assign rd_val   = rf_q[rd_idx];
  assign rs_val   = rf_q[rs_idx];
  assign add_sum  = {1'b0, rd_val} + {1'b0, rs_val};
  // The extra top bit of the difference is the borrow out of the subtraction.
  assign sub_diff = {1'b0, rd_val} - {1'b0, rs_val};

  assign mem_we   = bus.wr && (state_q == ST_IDLE || state_q == ST_HALT);

  always_comb begin
    // NOTE: every signal gets a default before the case so no path can infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    z_d       = z_q;
    c_d       = c_q;
    err_d     = err_q;
    y_d       = y_q;
    y_valid_d = 1'b0;
    rf_we     = 1'b0;
    rf_wdata  = '0;

    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (bus.start) begin
          pc_d    = '0;
          z_d     = 1'b0;
          c_d     = 1'b0;
          err_d   = 1'b0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_EXEC;
      ST_EXEC: begin
        state_d = ST_FETCH;
        pc_d    = pc_q + 1'b1;
        case (op)
          OP_NOP: ;
          OP_LDI: begin rf_we = 1'b1; rf_wdata = imm_ext; end
          OP_ADD: begin
            rf_we = 1'b1; rf_wdata = add_sum[DATA_WIDTH-1:0];
            c_d = add_sum[DATA_WIDTH]; z_d = (add_sum[DATA_WIDTH-1:0] == '0);
          end
          OP_SUB: begin
            rf_we = 1'b1; rf_wdata = sub_diff[DATA_WIDTH-1:0];
            c_d = sub_diff[DATA_WIDTH]; z_d = (sub_diff[DATA_WIDTH-1:0] == '0);
          end
          OP_AND: begin
            rf_we = 1'b1; rf_wdata = rd_val & rs_val;
            c_d = 1'b0; z_d = ((rd_val & rs_val) == '0);
          end
          OP_OR: begin
            rf_we = 1'b1; rf_wdata = rd_val | rs_val;
            c_d = 1'b0; z_d = ((rd_val | rs_val) == '0);
          end
          OP_XOR: begin
            rf_we = 1'b1; rf_wdata = rd_val ^ rs_val;
            c_d = 1'b0; z_d = ((rd_val ^ rs_val) == '0);
          end
          OP_SHL: begin
            rf_we = 1'b1; rf_wdata = rd_val << 1;
            c_d = rd_val[DATA_WIDTH-1]; z_d = ((rd_val << 1) == '0);
          end
          OP_SHR: begin
            rf_we = 1'b1; rf_wdata = rd_val >> 1;
            c_d = rd_val[0]; z_d = ((rd_val >> 1) == '0);
          end
          OP_MOV: begin rf_we = 1'b1; rf_wdata = rs_val; end
          OP_OUT: begin y_d = rd_val; y_valid_d = 1'b1; end
          OP_JMP: pc_d = ir_q[ADDR_WIDTH-1:0];
          OP_JZ:  if (z_q) pc_d = ir_q[ADDR_WIDTH-1:0];
          OP_HALT: state_d = ST_HALT;
          default: begin
            state_d = ST_HALT;
            err_d   = 1'b1;
          end
        endcase
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the instruction memory has no reset; a program must survive a core reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[bus.wr_addr] <= bus.wr_instr;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      z_q       <= 1'b0;
      c_q       <= 1'b0;
      err_q     <= 1'b0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      for (int i = 0; i < 4; i++) rf_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      z_q       <= z_d;
      c_q       <= c_d;
      err_q     <= err_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      if (state_q == ST_FETCH) ir_q <= mem_q[pc_q];
      if (rf_we) rf_q[rd_idx] <= rf_wdata;
    end
  end

  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign bus.busy    = (state_q == ST_FETCH) || (state_q == ST_EXEC);
  assign bus.halted  = (state_q == ST_HALT);
  assign bus.err     = err_q;
endmodule

// File: tb/tb_seq_cpu.sv
// Self-checking bench for seq_cpu: directed programs plus random programs, each
// compared with an instruction-level interpreter that predicts outputs and timing.
module tb_seq_cpu;
  localparam int     DW    = 8;
  localparam int     AW    = 4;
  localparam int     DEPTH = 1 << AW;
  localparam longint MOD   = longint'(1) << DW;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  seq_cpu_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
  seq_cpu #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;

  // Reference state: memory image, register file, predicted output stream and timing.
  logic [15:0]   m_mem [DEPTH];
  longint        m_rf [4];
  logic [DW-1:0] exp_y [$];
  int            exp_cyc [$];
  int            exp_halt_cyc;
  bit            exp_err;
  logic [DW-1:0] obs_y [$];
  int            obs_cyc [$];
  int            obs_halt_cyc;

  function automatic logic [15:0] enc(int op, int rd, int rs, int imm);
    logic [15:0] w;
    w = {4'(op), 2'(rd), 2'(rs), 8'(imm)};
    return w;
  endfunction

  // Interpreter: instruction n (counted from start) executes in cycle 2n+2; its
  // register/y effects appear in the following cycle.
  task automatic model_run();
    int pc, n, op, rd, rs, imm, npc, ex;
    bit z, c, done;
    longint a, b, r;
    logic [15:0] ins;
    pc = 0; n = 0; z = 0; c = 0; done = 0; r = 0;
    exp_y.delete(); exp_cyc.delete();
    exp_err = 0; exp_halt_cyc = 100000;
    while (!done && n < 2000) begin
      ins = m_mem[pc];
      op = int'(ins[15:12]); rd = int'(ins[11:10]); rs = int'(ins[9:8]); imm = int'(ins[7:0]);
      a = m_rf[rd]; b = m_rf[rs]; ex = 2 * n + 2; npc = (pc + 1) % DEPTH;
      case (op)
        0: ;
        1: m_rf[rd] = imm;
        2: begin r = a + b; c = (r >= MOD); r = r % MOD; end
        3: begin c = (a < b); r = (a - b + MOD) % MOD; end
        4: begin r = a & b; c = 0; end
        5: begin r = a | b; c = 0; end
        6: begin r = a ^ b; c = 0; end
        7: begin c = (a >= MOD / 2); r = (2 * a) % MOD; end
        8: begin c = ((a % 2) == 1); r = a / 2; end
        9: m_rf[rd] = b;
        10: begin exp_y.push_back(DW'(a)); exp_cyc.push_back(ex + 1); end
        11: npc = imm % DEPTH;
        12: if (z) npc = imm % DEPTH;
        default: begin done = 1; exp_err = (op >= 14); exp_halt_cyc = ex + 1; end
      endcase
      if (op >= 2 && op <= 8) begin z = (r == 0); m_rf[rd] = r; end
      pc = npc;
      n++;
    end
  endtask

  task automatic write_word(input int addr, input logic [15:0] data);
    @(negedge clk);
    bus.wr = 1'b1; bus.wr_addr = AW'(addr); bus.wr_instr = data;
    @(negedge clk);
    bus.wr = 1'b0;
    m_mem[addr] = data;
  endtask

  // Runs the loaded program and compares it with the interpreter.
  // wr_mode 1: write (waddr,wdata) in the start cycle; 2: attempt the write mid-run.
  task automatic run_and_compare(input string name, input int wr_mode,
                                 input int waddr, input logic [15:0] wdata);
    int  cyc, budget, n;
    bit  halted_seen, busy_bad;
    if (wr_mode == 1) m_mem[waddr] = wdata;
    model_run();
    budget = exp_halt_cyc + 5;
    obs_y.delete(); obs_cyc.delete(); obs_halt_cyc = -1;
    halted_seen = 0; busy_bad = 0; cyc = 0;
    @(negedge clk);
    bus.start = 1'b1;
    if (wr_mode == 1) begin bus.wr = 1'b1; bus.wr_addr = AW'(waddr); bus.wr_instr = wdata; end
    while (cyc < budget && !halted_seen) begin
      @(negedge clk);
      cyc++;
      bus.start = 1'b0; bus.wr = 1'b0;
      if (wr_mode == 2 && cyc == 3) begin
        bus.wr = 1'b1; bus.wr_addr = AW'(waddr); bus.wr_instr = wdata;
      end
      if (bus.y_valid === 1'b1) begin obs_y.push_back(bus.y); obs_cyc.push_back(cyc); end
      if (bus.busy !== (cyc < exp_halt_cyc)) busy_bad = 1;
      if (bus.halted === 1'b1) begin halted_seen = 1; obs_halt_cyc = cyc; end
    end
    bus.wr = 1'b0;

    checks++;
    if (obs_halt_cyc !== exp_halt_cyc) begin
      errors++; $display("FAIL %s halt_cycle: got %0d expected %0d", name, obs_halt_cyc, exp_halt_cyc);
    end
    checks++;
    if (obs_y.size() !== exp_y.size()) begin
      errors++; $display("FAIL %s out_count: got %0d expected %0d", name, obs_y.size(), exp_y.size());
    end
    n = (obs_y.size() < exp_y.size()) ? obs_y.size() : exp_y.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (obs_y[i] !== exp_y[i] || obs_cyc[i] !== exp_cyc[i]) begin
        errors++;
        $display("FAIL %s out[%0d]: got y=%0h@%0d expected y=%0h@%0d",
                 name, i, obs_y[i], obs_cyc[i], exp_y[i], exp_cyc[i]);
      end
    end
    checks++;
    if (bus.err !== exp_err) begin
      errors++; $display("FAIL %s err: got %b expected %b", name, bus.err, exp_err);
    end
    checks++;
    if (busy_bad !== 1'b0) begin
      errors++; $display("FAIL %s busy_profile: got irregular busy expected high until halt", name);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.wr = 1'b0; bus.wr_addr = '0; bus.wr_instr = '0; bus.start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) m_rf[i] = 0;
    checks++;
    if (bus.y !== '0 || bus.y_valid !== 1'b0) begin
      errors++; $display("FAIL reset_y: got y=%0h v=%b expected 0/0", bus.y, bus.y_valid);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.halted !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_status: got busy=%b halted=%b err=%b expected 0/0/0", bus.busy, bus.halted, bus.err);
    end
    for (int a = 0; a < DEPTH; a++) write_word(a, enc(13, 0, 0, 0));
  endtask

  task automatic test_basic_program();
    write_word(0, enc(1, 0, 0, 5));
    write_word(1, enc(1, 1, 0, 3));
    write_word(2, enc(2, 0, 1, 0));
    write_word(3, enc(10, 0, 0, 0));
    write_word(4, enc(13, 0, 0, 0));
    run_and_compare("basic", 0, 0, '0);
    checks++;
    if (obs_y.size() != 1 || obs_y[0] !== 8'd8 || obs_cyc[0] !== 9 || obs_halt_cyc !== 11) begin
      errors++;
      $display("FAIL basic_literal: got %0d outputs halt@%0d expected y=8@9 halt@11", obs_y.size(), obs_halt_cyc);
    end
  endtask

  task automatic test_carry_jz();
    write_word(0, enc(1, 0, 0, 8'hFF));
    write_word(1, enc(1, 1, 0, 1));
    write_word(2, enc(2, 0, 1, 0));
    write_word(3, enc(12, 0, 0, 5));
    write_word(4, enc(10, 1, 0, 0));
    write_word(5, enc(10, 0, 0, 0));
    write_word(6, enc(13, 0, 0, 0));
    run_and_compare("carry_jz", 0, 0, '0);
    checks++;
    if (obs_y.size() != 1 || obs_y[0] !== 8'h00) begin
      errors++; $display("FAIL carry_jz_literal: got %0d outputs expected one y=00", obs_y.size());
    end
  endtask

  task automatic test_countdown();
    write_word(0, enc(1, 0, 0, 3));
    write_word(1, enc(1, 1, 0, 1));
    write_word(2, enc(10, 0, 0, 0));
    write_word(3, enc(3, 0, 1, 0));
    write_word(4, enc(12, 0, 0, 6));
    write_word(5, enc(11, 0, 0, 2));
    write_word(6, enc(13, 0, 0, 0));
    run_and_compare("countdown", 0, 0, '0);
    checks++;
    if (obs_y.size() != 3 || obs_y[0] !== 8'd3 || obs_y[1] !== 8'd2 || obs_y[2] !== 8'd1) begin
      errors++; $display("FAIL countdown_literal: got %0d outputs expected 3,2,1", obs_y.size());
    end
  endtask

  // First pass falls through to OUT at the last address; after the wrap, Z is set
  // and the branch at address 0 leads to HALT.
  task automatic test_wrap();
    write_word(0, enc(12, 0, 0, 14));
    for (int a = 1; a < 12; a++) write_word(a, enc(0, 0, 0, 0));
    write_word(12, enc(6, 3, 3, 0));
    write_word(13, enc(11, 0, 0, 15));
    write_word(14, enc(13, 0, 0, 0));
    write_word(15, enc(10, 2, 0, 0));
    run_and_compare("wrap", 0, 0, '0);
  endtask

  task automatic test_write_protect();
    write_word(0, enc(1, 0, 0, 5));
    write_word(1, enc(1, 1, 0, 3));
    write_word(2, enc(2, 0, 1, 0));
    write_word(3, enc(10, 0, 0, 0));
    write_word(4, enc(13, 0, 0, 0));
    run_and_compare("wr_during_run", 2, 1, 16'hE000);
    run_and_compare("wr_protect_rerun", 0, 0, '0);
    write_word(0, 16'hE000);
    run_and_compare("illegal_op", 0, 0, '0);
    checks++;
    if (bus.err !== 1'b1 || bus.halted !== 1'b1) begin
      errors++; $display("FAIL illegal_literal: got err=%b halted=%b expected 1/1", bus.err, bus.halted);
    end
    write_word(0, enc(13, 0, 0, 0));
    run_and_compare("err_clear", 0, 0, '0);
  endtask

  task automatic test_reset_mid_run();
    write_word(0, enc(1, 0, 0, 7));
    write_word(1, enc(10, 0, 0, 0));
    write_word(2, enc(13, 0, 0, 0));
    @(negedge clk);
    bus.start = 1'b1;
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (cyc == 4) reset = 1'b1;
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) m_rf[i] = 0;
    checks++;
    if (bus.y_valid !== 1'b0 || bus.y !== '0) begin
      errors++; $display("FAIL reset_mid_out: got y=%0h v=%b expected 0/0", bus.y, bus.y_valid);
    end
    checks++;
    if (bus.busy !== 1'b0 || bus.halted !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_state: got busy=%b halted=%b err=%b expected idle", bus.busy, bus.halted, bus.err);
    end
    write_word(0, enc(13, 0, 0, 0));
    run_and_compare("halt_only", 0, 0, '0);
    run_and_compare("wr_with_start", 1, 0, enc(1, 0, 0, 8'h5A));
    checks++;
    if (obs_y.size() != 1 || obs_y[0] !== 8'h5A) begin
      errors++; $display("FAIL wr_with_start_literal: got %0d outputs expected one y=5A", obs_y.size());
    end
  endtask

  // Random programs: forward-only jumps guarantee termination; last word is HALT.
  task automatic test_random();
    int op, imm;
    for (int t = 0; t < 25; t++) begin
      for (int a = 0; a < DEPTH - 1; a++) begin
        op  = $urandom_range(0, 12);
        imm = $urandom_range(0, 255);
        if (op == 11 || op == 12) imm = $urandom_range(a + 1, DEPTH - 1);
        if ($urandom_range(0, 39) == 0) op = $urandom_range(13, 15);
        write_word(a, enc(op, $urandom_range(0, 3), $urandom_range(0, 3), imm));
      end
      write_word(DEPTH - 1, enc(13, 0, 0, 0));
      run_and_compare($sformatf("random%0d", t), 0, 0, '0);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_basic_program();
    test_carry_jz();
    test_countdown();
    test_wrap();
    test_write_protect();
    test_reset_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
